// File: rtl/pipeline_issue_queue.sv
// pipeline_issue_queue: FIFO-buffered issue stage with a registered output register feeding the
// ALU/parity pipeline. Define PIPELINE_ISSUE_ONEHOT_CHECK_EN to screen out non-one-hot fncodes.
module pipeline_issue_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_fncode,
    input  logic [3:0]               in_srcA,
    input  logic [3:0]               in_srcB,
    output logic                     out_valid,
    input  logic                     out_stall,
    output logic [7:0]               out_fncode,
    output logic [3:0]               out_srcA,
    output logic [3:0]               out_srcB,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     bad_fncode,
    output logic [7:0]               drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [15:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             push;
    logic             fncode_ok;
    logic             write_en;
    logic             adv;
    logic             pop;

    // in_ready looks only at registered occupancy, so out_stall never reaches it combinationally
    assign full     = (count == CNT_FULL);
    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;
    assign adv      = !out_valid || !out_stall;
    assign pop      = adv && (count != '0);
    assign write_en = push && fncode_ok;

`ifdef PIPELINE_ISSUE_ONEHOT_CHECK_EN
    assign fncode_ok = (in_fncode != 8'd0) && ((in_fncode & (in_fncode - 8'd1)) == 8'd0);
`else
    assign fncode_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[wr_ptr] <= {in_fncode, in_srcA, in_srcB};
        end
    end

    // Output register only reloads when empty or being consumed; a stalled operation is held
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            out_valid  <= 1'b0;
            out_fncode <= '0;
            out_srcA   <= '0;
            out_srcB   <= '0;
        end else begin
            if (write_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (adv) begin
                out_valid <= (count != '0);
                if (pop) begin
                    {out_fncode, out_srcA, out_srcB} <= mem[rd_ptr];
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
            end
            if (write_en && !pop) begin
                count <= count + CNT_ONE;
            end else if (!write_en && pop) begin
                count <= count - CNT_ONE;
            end
        end
    end

`ifdef PIPELINE_ISSUE_ONEHOT_CHECK_EN
    // Rejected handshakes are still consumed; flag them one cycle later and tally them
    always_ff @(posedge clk) begin
        if (rst) begin
            bad_fncode <= 1'b0;
            drop_count <= '0;
        end else begin
            bad_fncode <= push && !fncode_ok;
            if (push && !fncode_ok && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end
`else
    assign bad_fncode = 1'b0;
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_issue_queue.sv
// tb_pipeline_issue_queue: scoreboard bench for pipeline_issue_queue with directed scenarios
// followed by randomized traffic, stalls and occasional resets.
module tb_pipeline_issue_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef PIPELINE_ISSUE_ONEHOT_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_fncode = '0;
    logic [3:0]    in_srcA = '0;
    logic [3:0]    in_srcB = '0;
    logic          out_valid;
    logic          out_stall = 1'b0;
    logic [7:0]    out_fncode;
    logic [3:0]    out_srcA;
    logic [3:0]    out_srcB;
    logic [CW-1:0] count;
    logic          bad_fncode;
    logic [7:0]    drop_count;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q[$];
    int m_fifo   = 0;
    bit m_out    = 1'b0;
    bit m_bad    = 1'b0;
    int m_drops  = 0;
    bit just_reset = 1'b0;

    pipeline_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fncode(in_fncode), .in_srcA(in_srcA), .in_srcB(in_srcB),
        .out_valid(out_valid), .out_stall(out_stall),
        .out_fncode(out_fncode), .out_srcA(out_srcA), .out_srcB(out_srcB),
        .count(count), .bad_fncode(bad_fncode), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    function automatic bit fncode_accepted(input logic [7:0] f);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(f[i]);
        return !CHECK_EN || (ones == 1);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs just after the edge; expected ops enter the scoreboard here
    task automatic applyStimulus(input bit v, input logic [7:0] f, input logic [3:0] a,
                                 input logic [3:0] b, input bit stall, input bit r);
        @(posedge clk);
        #1;
        rst       = r;
        in_valid  = v;
        in_fncode = f;
        in_srcA   = a;
        in_srcB   = b;
        out_stall = stall;
        if (v && !r && m_fifo < DEPTH && fncode_accepted(f)) exp_q.push_back({f, a, b});
    endtask

    // Monitor: compare against the model state, then step the model across the coming edge
    always @(negedge clk) begin
        bit acc;
        bit ok;
        if (rst) begin
            checkOutput("in_ready_in_reset", in_ready, 0);
            exp_q.delete();
            m_fifo = 0; m_out = 0; m_bad = 0; m_drops = 0;
            just_reset = 1'b1;
        end else begin
            checkOutput("in_ready", in_ready, m_fifo < DEPTH);
            checkOutput("count", count, m_fifo);
            checkOutput("out_valid", out_valid, m_out);
            checkOutput("bad_fncode", bad_fncode, m_bad);
            checkOutput("drop_count", drop_count, m_drops);
            if (just_reset) checkOutput("reset_data", {out_fncode, out_srcA, out_srcB}, 0);
            just_reset = 1'b0;
            if (m_out) begin
                if (exp_q.size() == 0) begin
                    checkOutput("scoreboard_nonempty", 0, 1);
                end else begin
                    checkOutput("out_data", {out_fncode, out_srcA, out_srcB}, exp_q[0]);
                    if (!out_stall) void'(exp_q.pop_front());
                end
            end
            acc = in_valid && (m_fifo < DEPTH);
            ok  = fncode_accepted(in_fncode);
            if (!m_out || !out_stall) begin
                if (m_fifo > 0) begin
                    m_out = 1'b1;
                    m_fifo--;
                end else begin
                    m_out = 1'b0;
                end
            end
            if (acc && ok) m_fifo++;
            m_bad = acc && !ok;
            if (m_bad && m_drops < 255) m_drops++;
        end
    end

    initial begin
        applyStimulus(0, 8'h00, 4'h0, 4'h0, 0, 1);
        applyStimulus(0, 8'h00, 4'h0, 4'h0, 0, 1);
        applyStimulus(0, 8'h00, 4'h0, 4'h0, 0, 0);

        // Single ADD, no stall
        applyStimulus(1, 8'h01, 4'h1, 4'h1, 0, 0);
        repeat (4) applyStimulus(0, 8'h00, 4'h0, 4'h0, 0, 0);

        // Burst into a stalled pipeline: the sixth push must bounce off a full queue
        for (int i = 0; i < 6; i++)
            applyStimulus(1, 8'h01 << i, 4'(i), 4'(i + 3), 1, 0);
        repeat (8) applyStimulus(0, 8'h00, 4'h0, 4'h0, 0, 0);

        // Back-to-back stream of every function code
        for (int i = 0; i < 8; i++)
            applyStimulus(1, 8'h01 << i, 4'(i + 5), 4'(15 - i), 0, 0);
        repeat (4) applyStimulus(0, 8'h00, 4'h0, 4'h0, 0, 0);

        // Full queue with simultaneous pop and push attempt
        for (int i = 0; i < 5; i++)
            applyStimulus(1, 8'h02, 4'(i), 4'h7, 1, 0);
        applyStimulus(1, 8'h10, 4'hA, 4'hB, 0, 0);
        repeat (7) applyStimulus(0, 8'h00, 4'h0, 4'h0, 0, 0);

        // Reset with queued operations and a valid output
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 8'h08, 4'(i), 4'h2, 1, 0);
        applyStimulus(0, 8'h00, 4'h0, 4'h0, 1, 1);
        repeat (5) applyStimulus(0, 8'h00, 4'h0, 4'h0, 0, 0);

        // Malformed function codes
        applyStimulus(1, 8'h03, 4'h3, 4'h4, 0, 0);
        applyStimulus(1, 8'h00, 4'h5, 4'h6, 0, 0);
        applyStimulus(1, 8'h04, 4'h7, 4'h8, 0, 0);
        repeat (5) applyStimulus(0, 8'h00, 4'h0, 4'h0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [7:0] f;
            if ($urandom_range(3) != 0) f = 8'h01 << $urandom_range(7);
            else                        f = 8'($urandom);
            applyStimulus(($urandom_range(2) != 0), f, 4'($urandom), 4'($urandom),
                          ($urandom_range(2) == 0), ($urandom_range(63) == 0));
        end
        repeat (10) applyStimulus(0, 8'h00, 4'h0, 4'h0, 0, 0);

        @(negedge clk);
        #1;
        checkOutput("drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_issue_queue.md
# pipeline_issue_queue

Issue stage that sits directly upstream of the 3-stage ALU/parity pipeline. It buffers incoming operations, each a one-hot `fncode[7:0]` with operands `srcA[3:0]` and `srcB[3:0]`, in a small FIFO. It presents one operation per cycle to the pipeline's fncode/srcA/srcB inputs through a registered output stage, with a valid/stall handshake. It absorbs upstream bursts and downstream stalls without losing or duplicating operations.

## Interface
- `DEPTH`, default 4: FIFO entries, excluding the output register. Power of two, ≥2.
- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `in_valid`  input  1  upstream offers an operation this cycle.
- `in_ready`  output  1  queue can accept; equals `!full && !rst`.
- `in_fncode`  input  8  one-hot function code (bit0 ADD … bit7 XNOR).
- `in_srcA`  input  4  operand A.
- `in_srcB`  input  4  operand B.
- `out_valid`  output  1  output register holds an operation for the pipeline.
- `out_stall`  input  1  pipeline cannot take the operation this cycle.
- `out_fncode`  output  8  to pipeline fncode.
- `out_srcA`  output  4  to pipeline srcA.
- `out_srcB`  output  4  to pipeline srcB.
- `count`  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH, excluding the output register.
- `bad_fncode`  output  1  one-cycle pulse when an operation is rejected (only with the check compiled in).
- `drop_count`  output  8  count of rejected operations; saturates at 255.

## Operation
- Accept: `in_valid && in_ready` → write {fncode, srcA, srcB} at the write pointer; write pointer +1 mod DEPTH.
- Full: `count == DEPTH` → `in_ready = 0`.
  - A push offered while full is ignored, even when a pop happens in the same cycle.
  - `in_ready` depends on registered `count` only; no combinational path from `out_stall`.
- Advance condition: `adv = !out_valid || !out_stall`.
  - `adv` and FIFO non-empty → output register loads the head entry; read pointer +1; `out_valid = 1`.
  - `adv` and FIFO empty → `out_valid = 0`; data outputs hold their last value.
  - `!adv` (valid and stalled) → output register and read pointer unchanged.
- Simultaneous push and pop with non-full FIFO → `count` unchanged; pointers both advance.
- Pointers wrap modulo DEPTH. `count` disambiguates full from empty.
- No bypass: an operation written to an empty queue reaches the output register on the following edge.
- Reset, including mid-operation: all in-flight and queued operations are discarded.
  - Pointers → 0; `count` → 0; `out_valid` → 0.
  - `out_fncode`/`out_srcA`/`out_srcB` → 0; `bad_fncode` → 0; `drop_count` → 0.
  - `in_ready` is 0 during the reset cycle and 1 on the first cycle after it.

## Timing
- Latency from accept edge N: entry in FIFO after edge N; `out_valid` with that data after edge N+1, given no stall and the output register free.
- Throughput: one operation per cycle sustained, with `in_valid` held high and `out_stall` low.
- An operation is consumed on an edge where `out_valid && !out_stall`. The pipeline samples the data in that cycle.
- Stall hold: while `out_valid && out_stall`, the outputs are stable cycle to cycle.
- Total buffering is DEPTH+1 operations: FIFO plus the output register.
- `bad_fncode` is registered: it asserts the cycle after the offending handshake, for exactly one cycle.

## Configuration
- Macro: `PIPELINE_ISSUE_ONEHOT_CHECK_EN`.
- Defined:
  - An accepted handshake whose `in_fncode` is not exactly one-hot (zero or ≥2 bits set) is consumed (`in_ready` as normal) but not written to the FIFO.
  - `bad_fncode` pulses; `drop_count` increments, saturating at 255.
- Undefined:
  - All accepted operations are enqueued unchanged.
  - `bad_fncode` is tied 0 and `drop_count` is tied 0.

## Test plan
- Reset, then push ADD (8'h01, A=1, B=1) with no stall → `out_valid` 2 cycles after accept; out = 01/1/1; `count` returns to 0.
- Hold `out_stall = 1` and push 5 ops (DEPTH = 4) → 1st op in the output register, `count = 4`, `in_ready = 0`; 6th push ignored. Release stall → ops emerge in order, one per cycle.
- Continuous push of 8 ops (fncode 01,02,…,80) with no stall → 8 consecutive `out_valid` cycles in order, no gaps after the first.
- With the queue full, pop and push attempted in the same cycle → push rejected, `count` 4→3.
- Assert `rst` for 1 cycle with 3 queued and out valid → next cycle: `out_valid = 0`, `count = 0`, outputs 0, `in_ready = 1`; no stale ops emerge afterwards.
- With `PIPELINE_ISSUE_ONEHOT_CHECK_EN`: push 8'h03, then 8'h00, then 8'h04 → two `bad_fncode` pulses, `drop_count = 2`, only XOR (04) emerges. Without the macro, all three emerge.
